// File: rtl/mem_wb_pipeline_register_if.sv
// MEM/WB stage bundle: incoming MEM-stage fields plus registered WB-stage outputs.
// Retired_Count_o exists only when WB_RETIRE_COUNT_EN is defined.
interface mem_wb_pipeline_register_if #(
    parameter int NBits       = 32,
    parameter int RegAddrBits = 5
);
    logic                   Stall_i;
    logic                   Flush_i;
    logic                   Valid_i;
    logic                   RegWrite_i;
    logic [1:0]             MemtoReg_i;
    logic [NBits-1:0]       ALU_Result_i;
    logic [NBits-1:0]       Read_Data_i;
    logic [NBits-1:0]       PC_Plus_4_i;
    logic [RegAddrBits-1:0] Write_Register_i;

    logic                   Valid_o;
    logic                   RegWrite_o;
    logic [1:0]             WB_Selector_o;
    logic [NBits-1:0]       ALU_Result_o;
    logic [NBits-1:0]       Read_Data_o;
    logic [NBits-1:0]       PC_Plus_4_o;
    logic [RegAddrBits-1:0] Write_Register_o;
    logic                   Illegal_Sel_o;
`ifdef WB_RETIRE_COUNT_EN
    logic [31:0]            Retired_Count_o;
`endif

    modport master (
        output Stall_i, Flush_i, Valid_i, RegWrite_i, MemtoReg_i,
               ALU_Result_i, Read_Data_i, PC_Plus_4_i, Write_Register_i,
        input
`ifdef WB_RETIRE_COUNT_EN
               Retired_Count_o,
`endif
               Valid_o, RegWrite_o, WB_Selector_o, ALU_Result_o, Read_Data_o,
               PC_Plus_4_o, Write_Register_o, Illegal_Sel_o
    );

    modport slave (
        input  Stall_i, Flush_i, Valid_i, RegWrite_i, MemtoReg_i,
               ALU_Result_i, Read_Data_i, PC_Plus_4_i, Write_Register_i,
        output
`ifdef WB_RETIRE_COUNT_EN
               Retired_Count_o,
`endif
               Valid_o, RegWrite_o, WB_Selector_o, ALU_Result_o, Read_Data_o,
               PC_Plus_4_o, Write_Register_o, Illegal_Sel_o
    );
endinterface

// File: rtl/mem_wb_pipeline_register.sv
// MEM/WB pipeline register with stall, flush, $zero-write suppression and illegal-selector trap.
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNT_EN.
module mem_wb_pipeline_register #(
    parameter int NBits       = 32,
    parameter int RegAddrBits = 5
) (
    input  logic clk,
    input  logic reset,
    mem_wb_pipeline_register_if.slave bus
);
    logic illegal_now;
    logic retire_now;

    // Selector code 3 is only meaningful on a real instruction; on a bubble it is loaded as-is.
    always_comb begin
        illegal_now = bus.Valid_i && (bus.MemtoReg_i == 2'd3);
        retire_now  = bus.Valid_i && !illegal_now;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.Valid_o          <= 1'b0;
            bus.RegWrite_o       <= 1'b0;
            bus.WB_Selector_o    <= '0;
            bus.ALU_Result_o     <= '0;
            bus.Read_Data_o      <= '0;
            bus.PC_Plus_4_o      <= '0;
            bus.Write_Register_o <= '0;
            bus.Illegal_Sel_o    <= 1'b0;
        end else if (bus.Flush_i) begin
            bus.Valid_o          <= 1'b0;
            bus.RegWrite_o       <= 1'b0;
            bus.WB_Selector_o    <= '0;
            bus.ALU_Result_o     <= '0;
            bus.Read_Data_o      <= '0;
            bus.PC_Plus_4_o      <= '0;
            bus.Write_Register_o <= '0;
        end else if (!bus.Stall_i) begin
            bus.Valid_o          <= retire_now;
            bus.RegWrite_o       <= retire_now && bus.RegWrite_i && (bus.Write_Register_i != '0);
            bus.WB_Selector_o    <= illegal_now ? 2'd0 : bus.MemtoReg_i;
            bus.ALU_Result_o     <= bus.ALU_Result_i;
            bus.Read_Data_o      <= bus.Read_Data_i;
            bus.PC_Plus_4_o      <= bus.PC_Plus_4_i;
            bus.Write_Register_o <= bus.Write_Register_i;
            bus.Illegal_Sel_o    <= bus.Illegal_Sel_o || illegal_now;
        end
    end

`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retired_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_count <= '0;
        end else if (!bus.Flush_i && !bus.Stall_i && retire_now) begin
            retired_count <= retired_count + 32'd1;
        end
    end

    assign bus.Retired_Count_o = retired_count;
`endif
endmodule

// File: tb/tb_mem_wb_pipeline_register.sv
// Randomized + directed bench for mem_wb_pipeline_register against a slot-level reference model.
module tb_mem_wb_pipeline_register;
    localparam int NB = 32;
    localparam int RB = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_wb_pipeline_register_if #(.NBits(NB), .RegAddrBits(RB)) bus();

    mem_wb_pipeline_register #(.NBits(NB), .RegAddrBits(RB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    bit armed = 1'b0;

    // Reference model: the WB slot as the spec describes it.
    logic          m_valid, m_regwrite, m_illegal;
    logic [1:0]    m_sel;
    logic [NB-1:0] m_alu, m_rd, m_pc;
    logic [RB-1:0] m_wr;
    logic [31:0]   m_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            {m_valid, m_regwrite, m_illegal, m_sel} = '0;
            {m_alu, m_rd, m_pc, m_wr} = '0;
            m_count = '0;
        end else if (bus.Flush_i) begin
            {m_valid, m_regwrite, m_sel} = '0;
            {m_alu, m_rd, m_pc, m_wr} = '0;
        end else if (!bus.Stall_i) begin
            bit bad, real_insn;
            bad       = bus.Valid_i && bus.MemtoReg_i == 2'd3;
            real_insn = bus.Valid_i && !bad;
            m_valid    = real_insn;
            m_regwrite = real_insn && bus.RegWrite_i && bus.Write_Register_i != 0;
            m_sel      = bad ? 2'd0 : bus.MemtoReg_i;
            m_alu      = bus.ALU_Result_i;
            m_rd       = bus.Read_Data_i;
            m_pc       = bus.PC_Plus_4_i;
            m_wr       = bus.Write_Register_i;
            if (bad) m_illegal = 1'b1;
            if (real_insn) m_count = m_count + 1;
        end
        armed = 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            check("valid",    64'(bus.Valid_o),          64'(m_valid));
            check("regwrite", 64'(bus.RegWrite_o),       64'(m_regwrite));
            check("wb_sel",   64'(bus.WB_Selector_o),    64'(m_sel));
            check("alu",      64'(bus.ALU_Result_o),     64'(m_alu));
            check("rdata",    64'(bus.Read_Data_o),      64'(m_rd));
            check("pc4",      64'(bus.PC_Plus_4_o),      64'(m_pc));
            check("wreg",     64'(bus.Write_Register_o), 64'(m_wr));
            check("illegal",  64'(bus.Illegal_Sel_o),    64'(m_illegal));
`ifdef WB_RETIRE_COUNT_EN
            check("count",    64'(bus.Retired_Count_o),  64'(m_count));
`endif
        end
    end

    task automatic rand_inputs(input int stall_pct, input int flush_pct);
        bus.Stall_i          = ($urandom_range(99) < stall_pct);
        bus.Flush_i          = ($urandom_range(99) < flush_pct);
        bus.Valid_i          = ($urandom_range(3) != 0);
        bus.RegWrite_i       = $urandom_range(1);
        bus.MemtoReg_i       = 2'($urandom_range(3));
        bus.ALU_Result_i     = $urandom;
        bus.Read_Data_i      = $urandom;
        bus.PC_Plus_4_i      = $urandom;
        bus.Write_Register_i = ($urandom_range(7) == 0) ? '0 : RB'($urandom);
    endtask

    task automatic load(input logic v, input logic rw, input logic [1:0] sel, input logic [RB-1:0] wr);
        rand_inputs(0, 0);
        bus.Valid_i = v;
        bus.RegWrite_i = rw;
        bus.MemtoReg_i = sel;
        bus.Write_Register_i = wr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset with every input driven nonzero; outputs must still clear.
    task automatic do_reset();
        reset = 1'b1;
        bus.Stall_i = 1'b1; bus.Flush_i = 1'b1; bus.Valid_i = 1'b1; bus.RegWrite_i = 1'b1;
        bus.MemtoReg_i = 2'd3;
        bus.ALU_Result_i = $urandom | 32'h1;
        bus.Read_Data_i  = $urandom | 32'h1;
        bus.PC_Plus_4_i  = $urandom | 32'h1;
        bus.Write_Register_i = RB'($urandom) | RB'(1);
        step();
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_valid",   64'(bus.Valid_o), 64'd0);
        check("rst_regwr",   64'(bus.RegWrite_o), 64'd0);
        check("rst_alu",     64'(bus.ALU_Result_o), 64'd0);
        check("rst_wreg",    64'(bus.Write_Register_o), 64'd0);
        check("rst_illegal", 64'(bus.Illegal_Sel_o), 64'd0);
`ifdef WB_RETIRE_COUNT_EN
        check("rst_count",   64'(bus.Retired_Count_o), 64'd0);
`endif

        // jal write-back to $ra
        load(1'b1, 1'b1, 2'd2, 5'd31);
        bus.PC_Plus_4_i = 32'h0040_0008;
        step();
        check("jal_valid", 64'(bus.Valid_o), 64'd1);
        check("jal_regwr", 64'(bus.RegWrite_o), 64'd1);
        check("jal_sel",   64'(bus.WB_Selector_o), 64'd2);
        check("jal_pc4",   64'(bus.PC_Plus_4_o), 64'h0040_0008);
        check("jal_wreg",  64'(bus.Write_Register_o), 64'd31);
`ifdef WB_RETIRE_COUNT_EN
        check("jal_count", 64'(bus.Retired_Count_o), 64'd1);
`endif

        // write to $zero is suppressed but the slot still retires
        do_reset();
        load(1'b1, 1'b1, 2'd2, 5'd0);
        step();
        check("zero_regwr", 64'(bus.RegWrite_o), 64'd0);
        check("zero_valid", 64'(bus.Valid_o), 64'd1);
`ifdef WB_RETIRE_COUNT_EN
        check("zero_count", 64'(bus.Retired_Count_o), 64'd1);
`endif

        // stall holds, then stall+flush loads a bubble
        do_reset();
        load(1'b1, 1'b1, 2'd0, 5'd9);
        bus.ALU_Result_i = 32'h1234;
        step();
        check("st_load_alu", 64'(bus.ALU_Result_o), 64'h1234);
        for (int i = 0; i < 3; i++) begin
            rand_inputs(100, 0);
            step();
            check("st_hold_alu", 64'(bus.ALU_Result_o), 64'h1234);
            check("st_hold_wreg", 64'(bus.Write_Register_o), 64'd9);
`ifdef WB_RETIRE_COUNT_EN
            check("st_hold_count", 64'(bus.Retired_Count_o), 64'd1);
`endif
        end
        rand_inputs(100, 100);
        bus.Valid_i = 1'b1;
        step();
        check("stfl_valid", 64'(bus.Valid_o), 64'd0);
        check("stfl_regwr", 64'(bus.RegWrite_o), 64'd0);
        check("stfl_alu",   64'(bus.ALU_Result_o), 64'd0);

        // illegal selector traps and stays sticky until reset
        do_reset();
        load(1'b1, 1'b1, 2'd3, 5'd5);
        step();
        check("ill_valid",   64'(bus.Valid_o), 64'd0);
        check("ill_regwr",   64'(bus.RegWrite_o), 64'd0);
        check("ill_sel",     64'(bus.WB_Selector_o), 64'd0);
        check("ill_flag",    64'(bus.Illegal_Sel_o), 64'd1);
        for (int i = 0; i < 10; i++) begin
            load(1'b1, 1'b1, 2'($urandom_range(2)), 5'd7);
            step();
            check("ill_sticky", 64'(bus.Illegal_Sel_o), 64'd1);
        end
        do_reset();
        check("ill_cleared", 64'(bus.Illegal_Sel_o), 64'd0);

        // selector 3 on a bubble is not a trap
        load(1'b0, 1'b1, 2'd3, 5'd4);
        step();
        check("bub3_flag", 64'(bus.Illegal_Sel_o), 64'd0);
        check("bub3_sel",  64'(bus.WB_Selector_o), 64'd3);

`ifdef WB_RETIRE_COUNT_EN
        // counter wrap: preload 0xFFFFFFFF during a stalled cycle
        do_reset();
        rand_inputs(100, 0);
        force dut.retired_count = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        step();
        release dut.retired_count;
        check("wrap_pre", 64'(bus.Retired_Count_o), 64'hFFFF_FFFF);
        load(1'b1, 1'b0, 2'd1, 5'd3);
        step();
        check("wrap_zero", 64'(bus.Retired_Count_o), 64'd0);
`endif

        // random traffic with occasional reset
        for (int i = 0; i < 2000; i++) begin
            rand_inputs(20, 10);
            reset = ($urandom_range(99) < 2);
            step();
        end
        reset = 1'b0;
        rand_inputs(0, 0);
        step();
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
